mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares the 4-to-1 NAND-gate multiplexer between four requesters. It drives the mux select pair `s1:s0` and grants exclusive ownership of the mux output to one requester at a time. It sits directly in front of `mux_4to1`: requester *i* owns data input *i* (a=0, b=1, c=2, d=3). An optional hold-limit prevents a requester from owning the mux indefinitely.

## Interface
- `MAX_HOLD`, 8, maximum grant length in cycles when the hold limit is compiled in; legal range 1..255; ignored otherwise.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request per requester; bit *i* = mux input *i*; held high for as long as ownership is wanted.
- `gnt`  out  4  one-hot grant, or all-zero when no requester owns the mux.
- `s0`  out  1  mux select LSB (owner index bit 0).
- `s1`  out  1  mux select MSB (owner index bit 1).
- `valid`  out  1  high when the mux output reflects the owner's input after a settling cycle.
- `preempt`  out  1  one-cycle pulse when a grant is force-released; constant 0 without the macro.

## Operation
- State machine: IDLE, SETTLE, OWN.
- Registered pointer `ptr[1:0]` holds the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE:
  - If any `req` bit is high, grant the first set bit in search order. Set `gnt`, load `s1:s0` with its index, and go to SETTLE.
  - Otherwise stay in IDLE with `gnt`=0. `s1:s0` keep their last value so the mux select does not glitch.
- SETTLE:
  - Lasts exactly one cycle, covering mux gate delay; `valid`=0.
  - Go to OWN, or to IDLE if the owner's `req` has already dropped.
- OWN:
  - `valid`=1 while the owner's `req` stays high.
  - When the owner's `req` goes low, the next edge clears `gnt` and `valid`, sets `ptr`=owner+1 (wraps 3→0), and returns to IDLE.
- Requests from non-owners never affect the current grant. They are only considered in IDLE.
- A release from SETTLE or OWN also updates `ptr`=owner+1.
- Reset values: `gnt`=0000, `s0`=0, `s1`=0, `valid`=0, `preempt`=0, `ptr`=0, state IDLE, hold counter 0.

## Timing
- `req` sampled high at edge *n* in IDLE:
  - `gnt` and `s1:s0` update at edge *n*+1.
  - `valid` rises at edge *n*+2.
- Owner `req` sampled low at edge *m*: `gnt` and `valid` fall at edge *m*+1.
- Earliest re-grant to any requester is edge *m*+2, giving one dead IDLE cycle between owners.
- `gnt` is never two-hot. `valid`=1 implies `gnt` is nonzero and `gnt[{s1,s0}]`=1.
- `rst` high at any edge, including mid-SETTLE or mid-OWN, forces reset values at that edge and overrides all other events. The first grant after reset is possible one edge after `rst` is sampled low.
- Simultaneous requests in IDLE are resolved purely by the `ptr` search order. Four continuously asserted requests that each drop after one OWN cycle are granted in order 0,1,2,3,0,…

## Configuration
- Macro `MUX_ARB_HOLD_LIMIT_EN`.
- Defined:
  - An 8-bit hold counter clears on entry to SETTLE and increments each cycle in SETTLE and OWN.
  - Force release happens when the counter reaches `MAX_HOLD` and another `req` bit is high at that edge. `gnt` and `valid` clear, `preempt` pulses for one cycle, `ptr`=owner+1, and the state goes to IDLE.
  - If no other requester is waiting, the counter saturates at `MAX_HOLD` and the owner keeps the grant.
  - A preempted requester that still holds `req` high competes normally in IDLE.
- Undefined: no counter, `preempt` tied to 0, and ownership lasts until the owner drops `req`.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=1111 → `gnt`=0000, `s1:s0`=00, `valid`=0. After release, `gnt`=0001 one edge later and `valid`=1 one edge after that.
- Single requester: `req`=0100 for 5 cycles, then 0000 → `gnt`=0100, `s1:s0`=10, `valid` high for 4 cycles. `gnt` clears one edge after `req` drops; `s1:s0` stays 10.
- Round-robin fairness: `req`=1111, with each owner dropping its `req` bit for one cycle after its first OWN cycle → grant order 0,1,2,3,0 with exactly one IDLE cycle between grants.
- Wrap and skip: `ptr`=3 (after owner 2 releases) with `req`=0101 → next `gnt`=0001 (index 0, not 2), `s1:s0`=00.
- Reset mid-grant: owner 1 in OWN, then `rst` pulses for one cycle → all outputs return to reset values at that edge and `ptr`=0, so the next grant with `req`=0011 goes to index 0.
- With `MUX_ARB_HOLD_LIMIT_EN` and `MAX_HOLD`=4: `req`=0011 held → owner 0 is force-released after 4 grant cycles (`preempt` pulses once), then owner 1 is granted. With only `req`=0001, owner 0 holds indefinitely and `preempt` stays 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Round-robin owner selection for the shared 4:1 NAND mux; drives
//            s1:s0 and a one-hot grant. Optional hold limit: MUX_ARB_HOLD_LIMIT_EN
// Revision : 1.0  initial release
// ============================================================================
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       s0,
   output logic       s1,
   output logic       valid,
   output logic       preempt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_OWN    = 2'd2
   } state_t;

   state_t     r_state;
   logic [1:0] r_ptr;
   logic [1:0] r_sel;
   logic [3:0] r_gnt;
   logic       r_valid;
   logic       r_preempt;

   logic [7:0] w_rot;
   logic [1:0] w_off;
   logic [1:0] w_pick;
   logic       w_owner_req;
   logic       w_force;

   // Rotate requests so the pointer position lands at bit 0, then take the lowest set bit.
   always_comb begin
      w_rot = {req, req} >> r_ptr;
      w_off = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (w_rot[k]) w_off = 2'(k);
      end
      w_pick      = r_ptr + w_off;
      w_owner_req = req[r_sel];
   end

`ifdef MUX_ARB_HOLD_LIMIT_EN
   logic [7:0] r_hold;
   logic [7:0] w_hold_next;
   logic       w_others;

   always_comb begin
      w_hold_next = (r_hold >= 8'(MAX_HOLD)) ? 8'(MAX_HOLD) : r_hold + 8'd1;
      w_others    = |(req & ~r_gnt);
      w_force     = (r_state != ST_IDLE) && (w_hold_next == 8'(MAX_HOLD)) && w_others;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold <= 8'd0;
      end else if (r_state == ST_IDLE) begin
         r_hold <= 8'd0;
      end else begin
         r_hold <= w_hold_next;
      end
   end
`else
   assign w_force = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= 2'd0;
         r_sel     <= 2'd0;
         r_gnt     <= 4'b0000;
         r_valid   <= 1'b0;
         r_preempt <= 1'b0;
      end else begin
         r_preempt <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // r_sel is left alone when idle so the mux select never glitches.
               if (|req) begin
                  r_gnt   <= 4'b0001 << w_pick;
                  r_sel   <= w_pick;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE, ST_OWN: begin
               if (!w_owner_req || w_force) begin
                  r_gnt     <= 4'b0000;
                  r_valid   <= 1'b0;
                  r_ptr     <= r_sel + 2'd1;
                  r_preempt <= w_owner_req & w_force;
                  r_state   <= ST_IDLE;
               end else begin
                  r_valid <= 1'b1;
                  r_state <= ST_OWN;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign s0      = r_sel[0];
   assign s1      = r_sel[1];
   assign valid   = r_valid;
   assign preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Purpose  : Directed stimulus for mux4_rr_arbiter with a cycle-level owner model
// Revision : 1.0  initial release
// ============================================================================
module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b1111;
   logic [3:0] gnt;
   logic       s0, s1, valid, preempt;

   int checks = 0;
   int errors = 0;
   bit done   = 1'b0;
   bit hold_window = 1'b0;
   int preempt_seen = 0;

   // Model: owner index (-1 = nobody), cycles owned, rotating start, mux select.
   int m_owner   = -1;
   int m_age     = 0;
   int m_ptr     = 0;
   int m_sel     = 0;
   bit m_valid   = 1'b0;
   bit m_preempt = 1'b0;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt),
      .s0(s0), .s1(s1), .valid(valid), .preempt(preempt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1; m_age = 0; m_ptr = 0; m_sel = 0; m_valid = 1'b0; m_preempt = 1'b0;
      end else begin
         m_preempt = 1'b0;
         if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
               if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            end
            if (m_owner >= 0) begin
               m_sel = m_owner; m_age = 0; m_valid = 1'b0;
            end
         end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; m_valid = 1'b0;
         end else if (HOLD_EN && (m_age + 1 >= MAX_HOLD) && ((req & ~(4'b0001 << m_owner)) != 4'b0000)) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; m_valid = 1'b0; m_preempt = 1'b1;
         end else begin
            m_age = m_age + 1; m_valid = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!done) begin
         logic [3:0] eg;
         logic [1:0] es;
         eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
         es = 2'(m_sel);
         checks++;
         if ({gnt, s1, s0, valid, preempt} !== {eg, es, m_valid, m_preempt}) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got gnt=%b sel=%b%b valid=%b preempt=%b want gnt=%b sel=%b valid=%b preempt=%b",
                     $time, gnt, s1, s0, valid, preempt, eg, es, m_valid, m_preempt);
         end
         if (hold_window && preempt) preempt_seen++;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] q);
      rst = r;
      req = q;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      // Reset with everyone requesting.
      step(1'b1, 4'b1111);
      step(1'b1, 4'b1111);
      chk("reset_gnt", {4'b0, gnt}, 8'b0000_0000);
      chk("reset_sel_valid", {5'b0, s1, s0, valid}, 8'b0000_0000);
      step(1'b0, 4'b1111);
      chk("first_grant", {4'b0, gnt}, 8'b0000_0001);
      chk("first_grant_valid_low", {7'b0, valid}, 8'd0);
      step(1'b0, 4'b1111);
      chk("first_valid", {7'b0, valid}, 8'd1);
      step(1'b0, 4'b1110);
      chk("release0_gnt", {4'b0, gnt}, 8'd0);

      // Round robin: owners 1,2,3,0 each drop after one OWN cycle.
      for (int i = 1; i <= 4; i++) begin
         logic [3:0] oh;
         oh = 4'b0001 << (i % 4);
         step(1'b0, 4'b1111);
         chk("rr_grant", {4'b0, gnt}, {4'b0, oh});
         chk("rr_sel", {6'b0, s1, s0}, 8'(i % 4));
         step(1'b0, 4'b1111);
         chk("rr_valid", {7'b0, valid}, 8'd1);
         step(1'b0, 4'b1111 & ~oh);
         chk("rr_release", {4'b0, gnt}, 8'd0);
      end

      // Single requester 2 for five cycles.
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0100);
      chk("single_gnt", {4'b0, gnt}, 8'b0000_0100);
      chk("single_sel", {6'b0, s1, s0}, 8'b0000_0010);
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0100);
      chk("single_valid", {7'b0, valid}, 8'd1);
      step(1'b0, 4'b0000);
      chk("single_release_gnt", {4'b0, gnt}, 8'd0);
      chk("single_sel_held", {6'b0, s1, s0}, 8'b0000_0010);

      // Pointer is 3: index 0 wins over 2.
      step(1'b0, 4'b0101);
      chk("wrap_gnt", {4'b0, gnt}, 8'b0000_0001);
      chk("wrap_sel", {6'b0, s1, s0}, 8'd0);
      step(1'b0, 4'b0000);
      chk("settle_drop_gnt", {4'b0, gnt}, 8'd0);

      // Reset while owner 1 is in OWN.
      step(1'b0, 4'b0010);
      step(1'b0, 4'b0010);
      chk("own1", {3'b0, gnt, valid}, 8'b0000_0101);
      step(1'b1, 4'b0010);
      chk("midreset", {3'b0, gnt, s1, s0, valid}, 8'd0);
      step(1'b0, 4'b0011);
      chk("post_reset_grant", {4'b0, gnt}, 8'b0000_0001);

      // Hold limit with a competitor waiting.
      hold_window = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b0, 4'b0011);
      hold_window = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      chk("hold_gnt", {4'b0, gnt}, 8'b0000_0010);
      chk("hold_preempts", 8'(preempt_seen), 8'd1);
`else
      chk("hold_gnt", {4'b0, gnt}, 8'b0000_0001);
      chk("hold_preempts", 8'(preempt_seen), 8'd0);
`endif
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0000);

      // Lone requester keeps ownership.
      for (int i = 0; i < 9; i++) step(1'b0, 4'b0001);
      chk("lone_hold", {3'b0, gnt, valid}, 8'b0000_0011);
      chk("lone_no_preempt", {7'b0, preempt}, 8'd0);
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0000);

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
